// File: rtl/fetch_stage.sv
// Instruction-fetch stage: req/ack fetch FSM feeding an IF/ID register with a 1-entry skid buffer.
// Optional feature macro: FETCH_PERF_EN adds a 32-bit fetch-stall cycle counter output.
module fetch_stage #(
  parameter int ADDR_W  = 24,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               branchFlag,
  input  logic               stall,
  output logic               pcEn,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_stall_cnt,
`endif
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SQUASH} state_e;

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic                 if_valid_q, if_valid_d;
  logic [INSTR_W-1:0]   if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]    if_pc_q, if_pc_d;
  logic                 skid_v_q, skid_v_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
  logic                 accept, branch_act, hold;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    if_valid_d   = if_valid_q;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    imem_req     = 1'b0;
    pcEn         = 1'b0;
    accept       = 1'b0;
    branch_act   = 1'b0;
    imem_addr    = pend_q ? req_addr_q : pc;
    hold         = if_valid_q & stall;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        imem_req   = !skid_v_q;
        branch_act = branchFlag;
        accept     = imem_req & imem_ack & !branchFlag;
        pcEn       = accept | branchFlag;
        // A request already presented to memory must still complete; its data is dropped.
        if (branchFlag && imem_req && !imem_ack) state_d = S_SQUASH;
      end
      S_SQUASH: begin
        imem_req   = 1'b1;
        branch_act = branchFlag;
        pcEn       = branchFlag;
        if (imem_ack) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase

    // Freeze the address once a request is waiting so pc movement cannot disturb it.
    pend_d     = imem_req & !imem_ack;
    req_addr_d = pend_d ? imem_addr : req_addr_q;

    if (branch_act) begin
      if_valid_d = 1'b0;
      skid_v_d   = 1'b0;
    end else if (skid_v_q) begin
      if (!hold) begin
        if_valid_d = 1'b1;
        if_instr_d = skid_instr_q;
        if_pc_d    = skid_pc_q;
        skid_v_d   = 1'b0;
      end
    end else if (accept) begin
      if (!hold) begin
        if_valid_d = 1'b1;
        if_instr_d = imem_rdata;
        if_pc_d    = imem_addr;
      end else begin
        skid_v_d     = 1'b1;
        skid_instr_d = imem_rdata;
        skid_pc_d    = imem_addr;
      end
    end else if (if_valid_q && !stall) begin
      if_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pend_q       <= 1'b0;
      req_addr_q   <= '0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      req_addr_q   <= req_addr_d;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign if_valid = if_valid_q;
  assign if_instr = if_instr_q;
  assign if_pc    = if_pc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall_cycle;

  always_comb begin
    stall_cycle = (imem_req & !imem_ack) | skid_v_q | (state_q == S_SQUASH);
    perf_d      = perf_q + {31'd0, stall_cycle};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_stall_cnt = perf_q;
`endif

endmodule
